// File: rtl/intersection_ctrl.sv
// Two-phase traffic intersection controller with pedestrian walk service.
// Sequences NS/EW greens, yellows and all-red clearances on enabled edges.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   enable         1 = sequencing advances, 0 = freeze
//   ns_car/ew_car  vehicle presence sensors (level)
//   ped_ns_req     pedestrian request, NS crossing (pulse or level)
//   ped_ew_req     pedestrian request, EW crossing (pulse or level)
//   ns_* / ew_*    registered lamp drives, exactly one lit per approach
//   ns_walk/ew_walk registered walk lamps
//   phase          registered state code (0..5)
module intersection_ctrl #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_ns_req,
    input  logic       ped_ew_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ns_walk,
    output logic       ew_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5
    } state_e;

    localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
    localparam logic [7:0] ARED_M1 = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_L  = 8'(WALK_T);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       ns_ped_q, ns_ped_d;
    logic       ew_ped_q, ew_ped_d;
    logic       ns_srv_q, ns_srv_d;
    logic       ew_srv_q, ew_srv_d;

    logic       ns_red_q, ns_red_d;
    logic       ns_yel_q, ns_yel_d;
    logic       ns_grn_q, ns_grn_d;
    logic       ew_red_q, ew_red_d;
    logic       ew_yel_q, ew_yel_d;
    logic       ew_grn_q, ew_grn_d;
    logic       ns_walk_q, ns_walk_d;
    logic       ew_walk_q, ew_walk_d;

    logic       ns_dem;
    logic       ew_dem;
    logic       ns_enter;
    logic       ew_enter;

    // Next-state and dwell counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        ns_dem  = ns_car | ns_ped_q;
        ew_dem  = ew_car | ew_ped_q;

        unique case (state_q)
            NS_GREEN: begin
                if ((ew_dem && cnt_q >= GMIN_M1) ||
                    cnt_q >= GMAX_M1)
                    state_d = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (cnt_q >= YEL_M1)
                    state_d = ALL_RED_1;
            end
            ALL_RED_1: begin
                if (cnt_q >= ARED_M1)
                    state_d = EW_GREEN;
            end
            EW_GREEN: begin
                if ((ns_dem && cnt_q >= GMIN_M1) ||
                    cnt_q >= GMAX_M1)
                    state_d = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (cnt_q >= YEL_M1)
                    state_d = ALL_RED_2;
            end
            ALL_RED_2: begin
                if (cnt_q >= ARED_M1)
                    state_d = NS_GREEN;
            end
            default: begin
                state_d = ALL_RED_2;
            end
        endcase

        // Any state change restarts the dwell count; this also
        // covers recovery from an illegal code.
        if (state_d != state_q)
            cnt_d = 8'd0;

        // Paused: sensors are ignored and everything holds.
        if (!enable) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Pedestrian latches and walk service
    always_comb begin
        ns_enter = enable && (state_d == NS_GREEN) &&
                   (state_q != NS_GREEN);
        ew_enter = enable && (state_d == EW_GREEN) &&
                   (state_q != EW_GREEN);

        // A request on the entry edge is folded into this service
        // rather than left pending for the next cycle.
        ns_ped_d = ns_ped_q | ped_ns_req;
        ns_srv_d = ns_srv_q;
        if (ns_enter) begin
            ns_ped_d = 1'b0;
            ns_srv_d = ns_ped_q | ped_ns_req;
        end

        ew_ped_d = ew_ped_q | ped_ew_req;
        ew_srv_d = ew_srv_q;
        if (ew_enter) begin
            ew_ped_d = 1'b0;
            ew_srv_d = ew_ped_q | ped_ew_req;
        end

        ns_walk_d = (state_d == NS_GREEN) && ns_srv_d &&
                    (cnt_d < WALK_L);
        ew_walk_d = (state_d == EW_GREEN) && ew_srv_d &&
                    (cnt_d < WALK_L);
    end

    // Lamp decode of the next state, so lamps and phase
    // register on the same edge.
    always_comb begin
        ns_red_d = 1'b1;
        ns_yel_d = 1'b0;
        ns_grn_d = 1'b0;
        ew_red_d = 1'b1;
        ew_yel_d = 1'b0;
        ew_grn_d = 1'b0;

        unique case (state_d)
            NS_GREEN: begin
                ns_red_d = 1'b0;
                ns_grn_d = 1'b1;
            end
            NS_YELLOW: begin
                ns_red_d = 1'b0;
                ns_yel_d = 1'b1;
            end
            EW_GREEN: begin
                ew_red_d = 1'b0;
                ew_grn_d = 1'b1;
            end
            EW_YELLOW: begin
                ew_red_d = 1'b0;
                ew_yel_d = 1'b1;
            end
            default: begin
                ns_red_d = 1'b1;
                ew_red_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ALL_RED_2;
            cnt_q     <= 8'd0;
            ns_ped_q  <= 1'b0;
            ew_ped_q  <= 1'b0;
            ns_srv_q  <= 1'b0;
            ew_srv_q  <= 1'b0;
            ns_red_q  <= 1'b1;
            ns_yel_q  <= 1'b0;
            ns_grn_q  <= 1'b0;
            ew_red_q  <= 1'b1;
            ew_yel_q  <= 1'b0;
            ew_grn_q  <= 1'b0;
            ns_walk_q <= 1'b0;
            ew_walk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ns_ped_q  <= ns_ped_d;
            ew_ped_q  <= ew_ped_d;
            ns_srv_q  <= ns_srv_d;
            ew_srv_q  <= ew_srv_d;
            ns_red_q  <= ns_red_d;
            ns_yel_q  <= ns_yel_d;
            ns_grn_q  <= ns_grn_d;
            ew_red_q  <= ew_red_d;
            ew_yel_q  <= ew_yel_d;
            ew_grn_q  <= ew_grn_d;
            ns_walk_q <= ns_walk_d;
            ew_walk_q <= ew_walk_d;
        end
    end

    assign ns_red    = ns_red_q;
    assign ns_yellow = ns_yel_q;
    assign ns_green  = ns_grn_q;
    assign ew_red    = ew_red_q;
    assign ew_yellow = ew_yel_q;
    assign ew_green  = ew_grn_q;
    assign ns_walk   = ns_walk_q;
    assign ew_walk   = ew_walk_q;
    assign phase     = state_q;

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 10: minimum green duration, in enabled cycles.
REQ-002 Parameter GREEN_MAX, default 30: maximum green duration, in enabled cycles.
REQ-003 Parameter YELLOW_T, default 4: yellow duration, in enabled cycles.
REQ-004 Parameter ALLRED_T, default 2: all-red clearance duration, in enabled cycles.
REQ-005 Parameter WALK_T, default 6: walk-signal duration, in enabled cycles.
REQ-006 Legal parameter ranges SHALL be: all parameters 1..255; GREEN_MIN <= GREEN_MAX; WALK_T <= GREEN_MIN.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  high = sequencing advances; low = freeze.
REQ-010 ns_car, ew_car  in  1 each  vehicle-presence sensor per approach, level.
REQ-011 ped_ns_req, ped_ew_req  in  1 each  pedestrian button per approach, single-cycle or level.
REQ-012 ns_red, ns_yellow, ns_green  out  1 each  NS lamp drives, registered.
REQ-013 ew_red, ew_yellow, ew_green  out  1 each  EW lamp drives, registered.
REQ-014 ns_walk, ew_walk  out  1 each  pedestrian walk lamps, registered.
REQ-015 phase  out  3  current state encoding, registered.

Function
REQ-016 The FSM SHALL have these states and phase codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_1=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_2=5.
  - Codes 6-7 are illegal and SHALL go to ALL_RED_2 with the counter at 0 on the next enabled edge.
REQ-017 The cycle order SHALL be NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN.
REQ-018 An 8-bit dwell counter SHALL be 0 on state entry and SHALL increment on each enabled edge.
  - On an edge where the exit condition is true, the state SHALL advance and the counter SHALL load 0.
  - A fixed-duration state of duration D SHALL therefore persist exactly D enabled edges.
REQ-019 Exit conditions for the yellow and all-red states:
  - Yellow states exit at counter == YELLOW_T-1.
  - All-red states exit at counter == ALLRED_T-1.
REQ-020 Exit conditions for NS_GREEN:
  - Exit at counter >= GREEN_MIN-1 when EW demand is present, where EW demand = ew_car OR ew_ped_latch.
  - Otherwise exit at counter == GREEN_MAX-1.
  - EW_GREEN SHALL behave symmetrically, using NS demand = ns_car OR ns_ped_latch.
REQ-021 Pedestrian latches (set):
  - ns_ped_latch SHALL set on any edge where ped_ns_req=1, regardless of enable.
  - ew_ped_latch SHALL behave the same way with ped_ew_req.
REQ-022 Pedestrian latches (clear):
  - ns_ped_latch SHALL clear on the edge entering NS_GREEN; that green is then "walk-served".
  - A request coincident with the clearing edge SHALL be absorbed into that service.
  - A request arriving later during NS_GREEN SHALL re-set the latch for the next cycle.
  - ew_ped_latch SHALL behave symmetrically with EW_GREEN.
REQ-023 ns_walk SHALL be 1 only in a walk-served NS_GREEN while counter < WALK_T; ew_walk SHALL behave symmetrically.
REQ-024 Lamp outputs SHALL decode the next state and be registered on the same edge as the state.
  - Exactly one lamp per approach SHALL be lit at all times.
  - Both reds SHALL be lit in ALL_RED_1 and ALL_RED_2.
  - The red lamp of the non-green approach SHALL be lit in every green and yellow state.
REQ-025 When enable=0, state, counter, lamps and walk outputs SHALL hold; pedestrian latches SHALL still set.
REQ-026 Sensors SHALL be sampled only on enabled edges; sensor changes while paused SHALL have no effect until enable returns.

Reset
REQ-027 While reset=0, independent of clk, the block SHALL hold:
  - state ALL_RED_2, phase=5, counter=0;
  - ns_red=ew_red=1;
  - all yellow, green and walk outputs 0;
  - both pedestrian latches 0.
REQ-028 Reset asserted mid-cycle SHALL force the REQ-027 values immediately, with no yellow shown.
REQ-029 After release, NS_GREEN SHALL be entered on the ALLRED_T-th enabled edge.

Verification
REQ-030 Reset release, defaults, enable=1, no demand -> ns_green rises on edge 2, holds 30 edges, then yellow 4, all-red 2, EW_GREEN holds 30.
REQ-031 ew_car=1 from reset -> NS_GREEN lasts exactly 10 edges; phase sequence 0,1,2,3 with durations 10,4,2.
REQ-032 1-cycle ped_ns_req pulse during EW_GREEN -> ns_walk=1 for the first 6 edges of the next NS_GREEN; latch cleared on entry.
REQ-033 enable=0 for 5 cycles mid-NS_YELLOW with a ped_ew_req pulse -> all outputs frozen; yellow completes its remaining count after resume; ew_walk served in the next EW_GREEN.
REQ-034 reset asserted during EW_GREEN -> ew_green=0, ew_red=1, ns_red=1, phase=5 immediately, before the next clk edge.
REQ-035 All cycles -> assertion that each approach has exactly one lamp lit, and that ns_green and ew_green are never both 1.
